result_bcd_converter: RTL and testbench

Sequential signed-binary-to-BCD converter that sits directly downstream of the signed 20-bit `result` producer in the exam datapath. It accepts one two's-complement word through a valid/ready handshake. It converts the magnitude to packed BCD with a multi-cycle shift-add-3 (double-dabble) engine and presents sign plus digits to the seven-segment display driver. It holds the output until the consumer acknowledges it.

---
 rtl/result_bcd_converter.sv | 117 +++++++++++
 tb/tb_result_bcd_converter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/result_bcd_converter.sv
// Signed binary to packed BCD converter (shift-add-3) with valid/ready
// handshakes on both sides; output is held until the consumer takes it.
//
// Ports:
//   clk, rst (async, active-low)
//   in_valid / in_ready / in_data    : signed word from the result producer
//   out_valid / out_ready            : finished conversion handshake
//   out_neg, out_bcd                 : sign and packed BCD magnitude
//   busy                             : conversion running or result pending
module result_bcd_converter #(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_neg,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic                busy
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic           neg;
  logic [WIDTH-1:0] mag;
  logic [BW-1:0]  bcd;
  logic [BW-1:0]  adj;
  logic [BW-1:0]  bcd_sh;
  logic [CW-1:0]  cnt;
  logic           last;
  logic           accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == CW'(WIDTH - 1));

  // Add 3 to every nibble >= 5 so the following shift carries
  // correctly into the next decimal digit.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  assign bcd_sh = {adj[BW-2:0], mag[WIDTH-1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept)    state_nx = CONV;
      CONV: if (last)      state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  // Negating the most negative word yields 2^(WIDTH-1), which still
  // fits as an unsigned WIDTH-bit magnitude.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg     <= 1'b0;
      mag     <= '0;
      bcd     <= '0;
      cnt     <= '0;
      out_bcd <= '0;
      out_neg <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            neg <= in_data[WIDTH-1];
            mag <= in_data[WIDTH-1] ? -in_data : in_data;
            bcd <= '0;
            cnt <= '0;
          end
        end
        CONV: begin
          bcd <= bcd_sh;
          mag <= {mag[WIDTH-2:0], 1'b0};
          cnt <= cnt + CW'(1);
          if (last) begin
            out_bcd <= bcd_sh;
            out_neg <= neg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_bcd_converter.sv
// Scoreboard bench for result_bcd_converter: directed words with
// hand-computed BCD results, checked by an independent monitor.
module tb_result_bcd_converter;

  localparam int W = 20;
  localparam int D = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_neg;
  logic [4*D-1:0] out_bcd;
  logic          busy;

  result_bcd_converter #(.WIDTH(W), .DIGITS(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_neg   (out_neg),
    .out_bcd   (out_bcd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] bcd;
    logic        neg;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic prev_ov = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: compare each new result against the oldest expectation.
  always @(negedge clk) begin
    if (out_valid && !prev_ov) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0h want none", out_bcd);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_bcd", 32'(out_bcd), 32'(e.bcd));
        chk("out_neg", 32'(out_neg), 32'(e.neg));
        chk("latency", 32'(cyc), 32'(e.acc + W));
      end
    end
    prev_ov = out_valid;
  end

  task automatic send(input logic [W-1:0] d, input logic [23:0] eb,
                      input logic en, input bit push, input bit hold,
                      output int acc);
    int n;
    n = 0;
    acc = 0;
    in_data = d;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 want 1");
      in_valid = hold;
      return;
    end
    acc = cyc + 1;
    if (push) sb.push_back('{eb, en, acc});
    @(negedge clk);
    in_valid = hold;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_bcd"}, 32'(out_bcd), 32'h000000);
    chk({tag, "_out_neg"}, 32'(out_neg), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int a, a1, a2, a3, n;
    repeat (2) @(negedge clk);
    chk_reset("rst0");
    rst = 1'b1;
    @(negedge clk);

    send(20'd12345, 24'h012345, 1'b0, 1, 0, a);
    send(20'h80000, 24'h524288, 1'b1, 1, 0, a);
    send(20'd524287, 24'h524287, 1'b0, 1, 0, a);
    send(20'd0, 24'h000000, 1'b0, 1, 0, a);
    send(-20'sd1, 24'h000001, 1'b1, 1, 0, a);
    send(-20'sd99999, 24'h099999, 1'b1, 1, 0, a);

    // Backpressure: result must hold while the consumer stalls.
    n = 0;
    while ((out_valid || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    send(20'd54321, 24'h054321, 1'b0, 1, 0, a);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reach_done", 32'(out_valid), 32'd1);
    in_data = 20'd777;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_bcd", 32'(out_bcd), 32'h054321);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    send(20'd777, 24'h000777, 1'b0, 1, 0, a);

    // Back-to-back stream with both handshakes held high.
    send(20'd1, 24'h000001, 1'b0, 1, 1, a1);
    send(20'd10, 24'h000010, 1'b0, 1, 1, a2);
    send(20'd100, 24'h000100, 1'b0, 1, 0, a3);
    chk("b2b_gap1", 32'(a2 - a1), 32'd22);
    chk("b2b_gap2", 32'(a3 - a2), 32'd22);

    // Reset in the middle of a conversion.
    send(-20'sd4321, 24'h004321, 1'b1, 0, 0, a);
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk_reset("rst1");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_rst_idle", 32'(out_valid), 32'd0);
    send(20'd4321, 24'h004321, 1'b0, 1, 0, a);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
